// File: rtl/gate_pkg.sv
// Shared types and default widths for the gate driver slice.
// Holds the leg state enum and a dead-time state helper.
package gate_pkg;

    localparam int DEF_DT_W     = 8;
    localparam int DEF_PERIOD_W = 16;

    typedef enum logic [2:0] {
        OFF,
        DT_START,
        ON_H,
        DT_HL,
        ON_L,
        DT_LH
    } state_t;

    // true in any of the three dead-time states
    function automatic logic is_dead(input state_t s);
        return (s == DT_START) || (s == DT_HL) || (s == DT_LH);
    endfunction

endpackage

// File: rtl/period_meter.sv
// Switching period meter: cycles between successive high-side turn-ons.
// First start after a clear only arms the meter; later starts publish.
module period_meter
    import gate_pkg::*;
#(
    parameter int W = DEF_PERIOD_W
) (
    input  logic         i_clock,
    input  logic         i_RESET,
    input  logic         i_start,
    input  logic         i_clear,
    output logic [W-1:0] o_period,
    output logic         o_valid
);

    localparam logic [W-1:0] SAT = '1;

    logic [W-1:0] cnt;
    logic         armed;
    logic [W-1:0] cnt_inc;

    // saturating increment, also used for the published period
    assign cnt_inc = (cnt == SAT) ? SAT : cnt + W'(1);

    // counter, arm flag, period latch and one-cycle valid pulse
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            cnt      <= '0;
            armed    <= 1'b0;
            o_period <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                cnt   <= '0;
                armed <= 1'b0;
            end else if (i_start) begin
                cnt   <= '0;
                armed <= 1'b1;
                if (armed) begin
                    o_period <= cnt_inc;
                    o_valid  <= 1'b1;
                end
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/deadtime_gate_driver.sv
// Complementary bridge-leg gate driver with dead time and period meter.
// Define MIN_DWELL_EN to enforce a minimum on-time per conduction state.
module deadtime_gate_driver
    import gate_pkg::*;
#(
    parameter int DT_W      = DEF_DT_W,
    parameter int MIN_DWELL = 50,
    parameter int PERIOD_W  = DEF_PERIOD_W
) (
    input  logic                i_clock,
    input  logic                i_RESET,
    input  logic                i_sigma,
    input  logic                i_enable,
    input  logic [DT_W-1:0]     i_deadtime,
    output logic                o_gate_H,
    output logic                o_gate_L,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_period_valid
);

    logic [1:0]      sigma_sync;
    logic [1:0]      en_sync;
    logic            s_sigma;
    logic            s_en;
    state_t          state;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] dt_load;
    logic            dt_expire;
    logic            on_entry;
    logic            h_entry;
    logic            dwell_ok;
    logic            meter_clr;

    // two-flop synchronizers for the asynchronous sigma and enable
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            sigma_sync <= '0;
            en_sync    <= '0;
        end else begin
            sigma_sync <= {sigma_sync[0], i_sigma};
            en_sync    <= {en_sync[0], i_enable};
        end
    end

    assign s_sigma = sigma_sync[1];
    assign s_en    = en_sync[1];

    // a zero dead time still leaves one cycle with both gates low
    assign dt_load   = (i_deadtime == '0) ? DT_W'(1) : i_deadtime;
    assign dt_expire = is_dead(state) && (dt_cnt <= DT_W'(1));
    assign on_entry  = s_en && dt_expire;
    assign h_entry   = on_entry && s_sigma;
    assign meter_clr = (state == OFF);

`ifdef MIN_DWELL_EN
    localparam int DWELL_W = $clog2(MIN_DWELL + 2);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);

    logic [DWELL_W-1:0] dwell_cnt;

    // on-time counter, restarted at each turn-on, holds at the limit
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            dwell_cnt <= '0;
        end else if (on_entry) begin
            dwell_cnt <= '0;
        end else if (dwell_cnt != DWELL_MAX) begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
    end

    assign dwell_ok = (dwell_cnt == DWELL_MAX);
`else
    // no dwell limit: any sigma reversal may end a conduction state
    localparam bit DWELL_FREE = (MIN_DWELL >= 0) || 1'b1;

    assign dwell_ok = DWELL_FREE;
`endif

    // leg sequencer with registered gate outputs; disable wins
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state    <= OFF;
            dt_cnt   <= '0;
            o_gate_H <= 1'b0;
            o_gate_L <= 1'b0;
        end else if (!s_en) begin
            state    <= OFF;
            dt_cnt   <= '0;
            o_gate_H <= 1'b0;
            o_gate_L <= 1'b0;
        end else begin
            unique case (state)
                OFF: begin
                    state  <= DT_START;
                    dt_cnt <= dt_load;
                end
                DT_START, DT_HL, DT_LH: begin
                    if (dt_expire) begin
                        if (s_sigma) begin
                            state    <= ON_H;
                            o_gate_H <= 1'b1;
                        end else begin
                            state    <= ON_L;
                            o_gate_L <= 1'b1;
                        end
                    end else begin
                        dt_cnt <= dt_cnt - DT_W'(1);
                    end
                end
                ON_H: begin
                    if (!s_sigma && dwell_ok) begin
                        state    <= DT_HL;
                        dt_cnt   <= dt_load;
                        o_gate_H <= 1'b0;
                    end
                end
                ON_L: begin
                    if (s_sigma && dwell_ok) begin
                        state    <= DT_LH;
                        dt_cnt   <= dt_load;
                        o_gate_L <= 1'b0;
                    end
                end
                default: begin
                    state    <= OFF;
                    o_gate_H <= 1'b0;
                    o_gate_L <= 1'b0;
                end
            endcase
        end
    end

    period_meter #(
        .W (PERIOD_W)
    ) u_meter (
        .i_clock  (i_clock),
        .i_RESET  (i_RESET),
        .i_start  (h_entry),
        .i_clear  (meter_clr),
        .o_period (o_period),
        .o_valid  (o_period_valid)
    );

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Bench for deadtime_gate_driver: directed scenarios plus random
// sigma/enable/dead-time traffic against a cycle-level leg model.
module tb_deadtime_gate_driver;

    localparam int DT_W      = 8;
    localparam int PERIOD_W  = 16;
    localparam int MIN_DWELL = 50;
`ifdef MIN_DWELL_EN
    localparam int DWELL = MIN_DWELL;
`else
    localparam int DWELL = 0;
`endif

    logic                i_clock    = 1'b0;
    logic                i_RESET    = 1'b0;
    logic                i_sigma    = 1'b0;
    logic                i_enable   = 1'b0;
    logic [DT_W-1:0]     i_deadtime = '0;
    logic                o_gate_H;
    logic                o_gate_L;
    logic [PERIOD_W-1:0] o_period;
    logic                o_period_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    deadtime_gate_driver #(
        .DT_W      (DT_W),
        .MIN_DWELL (MIN_DWELL),
        .PERIOD_W  (PERIOD_W)
    ) dut (
        .i_clock        (i_clock),
        .i_RESET        (i_RESET),
        .i_sigma        (i_sigma),
        .i_enable       (i_enable),
        .i_deadtime     (i_deadtime),
        .o_gate_H       (o_gate_H),
        .o_gate_L       (o_gate_L),
        .o_period       (o_period),
        .o_period_valid (o_period_valid)
    );

    always #5 i_clock = ~i_clock;

    // reference model: side 0 = none, 1 = high, 2 = low
    int cyc;
    bit sd1, sd2, ed1, ed2;
    bit run, armed, m_pv;
    int side, dead, age, last_h, m_per;

    logic [18:0] dut_vec;
    logic [18:0] mdl_vec;
    assign dut_vec = {o_gate_H, o_gate_L, o_period_valid, o_period};
    assign mdl_vec = {side == 1, side == 2, m_pv, m_per[15:0]};

    function automatic int dmax(input logic [DT_W-1:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_tick();
        if (!i_RESET) begin
            cyc = 0; sd1 = 0; sd2 = 0; ed1 = 0; ed2 = 0;
            run = 0; armed = 0; m_pv = 0;
            side = 0; dead = 0; age = 0; last_h = 0; m_per = 0;
        end else begin
            cyc++;
            m_pv = 0;
            if (!ed2) begin
                run = 0; side = 0; dead = 0; armed = 0;
            end else if (!run) begin
                run = 1;
                dead = dmax(i_deadtime);
            end else if (dead > 0) begin
                dead--;
                if (dead == 0) begin
                    side = sd2 ? 1 : 2;
                    age = 0;
                    if (side == 1) begin
                        if (armed) begin
                            m_pv = 1;
                            m_per = (cyc - last_h > 65535) ? 65535 : cyc - last_h;
                        end
                        armed = 1;
                        last_h = cyc;
                    end
                end
            end else begin
                age++;
                if (age > DWELL && ((side == 1) != sd2)) begin
                    side = 0;
                    dead = dmax(i_deadtime);
                end
            end
            sd2 = sd1; sd1 = i_sigma;
            ed2 = ed1; ed1 = i_enable;
        end
    endtask

    // one clock: model advances on the edge, bench samples on the fall
    task automatic step();
        @(posedge i_clock);
        model_tick();
        @(negedge i_clock);
    endtask

    task automatic test_reset();
        i_RESET = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (o_gate_H !== 1'b0) $display("FAIL reset_gate_H got=%b exp=0", o_gate_H);
        else pass_cnt++;
        total_cnt++;
        if (o_gate_L !== 1'b0) $display("FAIL reset_gate_L got=%b exp=0", o_gate_L);
        else pass_cnt++;
        total_cnt++;
        if (o_period !== 16'd0) $display("FAIL reset_period got=%0d exp=0", o_period);
        else pass_cnt++;
        total_cnt++;
        if (o_period_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_period_valid);
        else pass_cnt++;
        i_RESET = 1'b1;
        repeat (4) begin
            step();
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL reset_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        int idx, rise, fall, lrise;
        bit ovl;
        i_deadtime = 8'd10; i_sigma = 1'b1; i_enable = 1'b1;
        idx = 0; rise = -1; ovl = 0;
        repeat (110) begin
            step(); idx++;
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL basic_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
            if (o_gate_H && rise < 0) rise = idx;
            if (o_gate_H && o_gate_L) ovl = 1;
        end
        total_cnt++;
        if (rise !== 13) $display("FAIL basic_h_rise got=%0d exp=13", rise);
        else pass_cnt++;
        i_sigma = 1'b0;
        idx = 0; fall = -1; lrise = -1;
        repeat (40) begin
            step(); idx++;
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL basic_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
            if (!o_gate_H && fall < 0) fall = idx;
            if (o_gate_L && lrise < 0) lrise = idx;
            if (o_gate_H && o_gate_L) ovl = 1;
        end
        total_cnt++;
        if (fall !== 3) $display("FAIL basic_h_fall got=%0d exp=3", fall);
        else pass_cnt++;
        total_cnt++;
        if (lrise !== 13) $display("FAIL basic_l_rise got=%0d exp=13", lrise);
        else pass_cnt++;
        total_cnt++;
        if (ovl) $display("FAIL basic_overlap got=1 exp=0");
        else pass_cnt++;
    endtask

    task automatic test_zero_dt();
        int idx, off_i, on_i;
        i_deadtime = 8'd0;
        repeat (60) step();
        for (int t = 0; t < 2; t++) begin
            i_sigma = (t == 0);
            idx = 0; off_i = -1; on_i = -1;
            repeat (70) begin
                step(); idx++;
                total_cnt++;
                if (dut_vec !== mdl_vec) $display("FAIL zero_dt_model got=%h exp=%h", dut_vec, mdl_vec);
                else pass_cnt++;
                if (off_i < 0 && !(t == 0 ? o_gate_L : o_gate_H)) off_i = idx;
                if (on_i < 0 && (t == 0 ? o_gate_H : o_gate_L)) on_i = idx;
            end
            total_cnt++;
            if (on_i - off_i !== 1 || off_i !== 3)
                $display("FAIL zero_dt_gap dir=%0d got=%0d..%0d exp=3..4", t, off_i, on_i);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        int idx, fall, back;
        bit l_seen;
        i_deadtime = 8'd10; i_sigma = 1'b1;
        repeat (80) step();
        i_sigma = 1'b0;
        idx = 0; fall = -1; back = -1; l_seen = 0;
        repeat (40) begin
            step(); idx++;
            if (idx == 3) i_sigma = 1'b1;
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL glitch_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
            if (!o_gate_H && fall < 0) fall = idx;
            if (o_gate_H && fall > 0 && back < 0) back = idx;
            if (o_gate_L) l_seen = 1;
        end
        total_cnt++;
        if (fall !== 3 || back !== 13) $display("FAIL glitch_h got=%0d/%0d exp=3/13", fall, back);
        else pass_cnt++;
        total_cnt++;
        if (l_seen) $display("FAIL glitch_l got=1 exp=0");
        else pass_cnt++;
    endtask

    task automatic test_period();
        int pulses;
        bit first, prev_h, sat_seen;
        i_enable = 1'b0;
        repeat (5) step();
        i_deadtime = 8'd5; i_enable = 1'b1;
        pulses = 0; first = 1; prev_h = 0;
        for (int i = 0; i < 1000; i++) begin
            i_sigma = ((i % 200) < 100);
            step();
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL period_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
            if (o_gate_H && !prev_h && first) begin
                first = 0;
                total_cnt++;
                if (o_period_valid !== 1'b0) $display("FAIL period_first got=1 exp=0");
                else pass_cnt++;
            end
            if (o_period_valid) begin
                pulses++;
                total_cnt++;
                if (o_period !== 16'd200) $display("FAIL period_value got=%0d exp=200", o_period);
                else pass_cnt++;
            end
            prev_h = o_gate_H;
        end
        total_cnt++;
        if (pulses !== 4) $display("FAIL period_pulses got=%0d exp=4", pulses);
        else pass_cnt++;
        i_sigma = 1'b0;
        repeat (65600) begin
            step();
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL period_hold_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
        end
        i_sigma = 1'b1;
        sat_seen = 0;
        repeat (30) begin
            step();
            if (o_period_valid) begin
                sat_seen = 1;
                total_cnt++;
                if (o_period !== 16'hFFFF) $display("FAIL period_sat got=%0d exp=65535", o_period);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (!sat_seen) $display("FAIL period_sat_pulse got=0 exp=1");
        else pass_cnt++;
    endtask

    task automatic test_enable_drop();
        int idx, off_i, rise;
        bit pv_at_rise, any_on;
        i_sigma = 1'b0; i_deadtime = 8'd5;
        repeat (70) step();
        i_enable = 1'b0;
        idx = 0; off_i = -1;
        repeat (10) begin
            step(); idx++;
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL drop_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
            if (off_i < 0 && !o_gate_H && !o_gate_L) off_i = idx;
        end
        total_cnt++;
        if (off_i !== 3) $display("FAIL drop_on_l got=%0d exp=3", off_i);
        else pass_cnt++;
        i_sigma = 1'b1; i_enable = 1'b1;
        idx = 0; rise = -1; pv_at_rise = 1;
        repeat (20) begin
            step(); idx++;
            if (o_gate_H && rise < 0) begin
                rise = idx;
                pv_at_rise = o_period_valid;
            end
        end
        total_cnt++;
        if (rise !== 8 || pv_at_rise !== 1'b0)
            $display("FAIL drop_reenable got=%0d/%b exp=8/0", rise, pv_at_rise);
        else pass_cnt++;
        repeat (60) step();
        i_deadtime = 8'd20; i_sigma = 1'b0;
        idx = 0; any_on = 0;
        repeat (40) begin
            step(); idx++;
            if (idx == 5) i_enable = 1'b0;
            if (idx > 7 && (o_gate_H || o_gate_L)) any_on = 1;
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL drop_dt_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
        end
        total_cnt++;
        if (any_on) $display("FAIL drop_dt_hl got=1 exp=0");
        else pass_cnt++;
        i_deadtime = 8'd7; i_enable = 1'b1;
        idx = 0; rise = -1;
        repeat (20) begin
            step(); idx++;
            if (o_gate_L && rise < 0) rise = idx;
        end
        total_cnt++;
        if (rise !== 10) $display("FAIL drop_restart got=%0d exp=10", rise);
        else pass_cnt++;
    endtask

    task automatic test_dwell();
        int idx, fall, exp_fall;
        bit got_h;
`ifdef MIN_DWELL_EN
        exp_fall = MIN_DWELL - 9;
`else
        exp_fall = 3;
`endif
        i_deadtime = 8'd4;
        repeat (60) step();
        i_sigma = 1'b1;
        got_h = 0;
        for (int i = 0; i < 100 && !got_h; i++) begin
            step();
            got_h = o_gate_H;
        end
        total_cnt++;
        if (!got_h) $display("FAIL dwell_h_on got=0 exp=1");
        else pass_cnt++;
        repeat (10) step();
        i_sigma = 1'b0;
        idx = 0; fall = -1;
        repeat (80) begin
            step(); idx++;
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL dwell_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
            if (!o_gate_H && fall < 0) fall = idx;
        end
        total_cnt++;
        if (fall !== exp_fall) $display("FAIL dwell_fall got=%0d exp=%0d", fall, exp_fall);
        else pass_cnt++;
    endtask

    task automatic test_random();
        repeat (3000) begin
            if ($urandom_range(0, 24) == 0) i_sigma = ~i_sigma;
            if (i_enable && $urandom_range(0, 399) == 0) i_enable = 1'b0;
            else if (!i_enable && $urandom_range(0, 9) == 0) i_enable = 1'b1;
            if ($urandom_range(0, 49) == 0) i_deadtime = DT_W'($urandom_range(0, 12));
            step();
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL random_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
            total_cnt++;
            if (o_gate_H && o_gate_L) $display("FAIL random_overlap got=11 exp=not both");
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        i_enable = 1'b1; i_sigma = 1'b1; i_deadtime = 8'd3;
        repeat (80) step();
        total_cnt++;
        if (o_gate_H !== 1'b1) $display("FAIL areset_pre got=%b exp=1", o_gate_H);
        else pass_cnt++;
        #2 i_RESET = 1'b0;
        #1;
        total_cnt++;
        if ({o_gate_H, o_gate_L, o_period_valid, o_period} !== 19'd0)
            $display("FAIL areset_now got=%h exp=0", dut_vec);
        else pass_cnt++;
        step();
        i_RESET = 1'b1;
        repeat (20) begin
            step();
            total_cnt++;
            if (dut_vec !== mdl_vec) $display("FAIL areset_model got=%h exp=%h", dut_vec, mdl_vec);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_dt();
        test_glitch();
        test_period();
        test_enable_drop();
        test_dwell();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
